// File: rtl/disp_sched_pkg.sv
// disp_sched_pkg
// Shared definitions for the display page scheduler: page count and width,
// page-index width, scheduler state encoding, and the round-robin page search.
package disp_sched_pkg;

    localparam int N_PAGE = 4;
    localparam int PAGE_W = 32;
    localparam int IDX_W  = 2;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_SHOW = 2'd1,
        ST_IDLE = 2'd2
    } state_e;

    // First enabled page after cur, looking at cur+1, cur+2, cur+3 and finally
    // cur itself. The loop runs from lowest to highest priority, so the last
    // hit (cur+1) wins. This builds a single-cycle priority scan. If no page
    // is enabled, cur is returned unchanged.
    function automatic logic [IDX_W-1:0] nextEnabled(input logic [IDX_W-1:0]  cur,
                                                     input logic [N_PAGE-1:0] en);
        logic [IDX_W-1:0] idx;
        nextEnabled = cur;
        for (int k = N_PAGE; k >= 1; k--) begin
            idx = cur + IDX_W'(k);
            if (en[idx]) begin
                nextEnabled = idx;
            end
        end
    endfunction

endpackage

// File: rtl/disp_sched_scan_clk_gen.sv
// disp_sched_scan_clk_gen
// Scan clock generator for the seven-segment scan path. It divides clk down to
// a 50 % scan clock and counts scan periods, one per digit. It flags the frame
// boundary, where the scan clock rises and the digit count wraps from 7 to 0.
//   clk_i        system clock
//   rst_i        synchronous active-high reset
//   clk1k_o      scan clock, toggles every DIV cycles
//   frameStb_o   combinational: the current cycle is a frame boundary
//   frameSync_o  registered one-cycle frame pulse (high while clk1k_o first
//                shows the rising edge of digit 0)
module disp_sched_scan_clk_gen #(
    parameter int DIV = 8
) (
    input  logic clk_i,
    input  logic rst_i,
    output logic clk1k_o,
    output logic frameStb_o,
    output logic frameSync_o
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] divCnt_q;
    logic          clk1k_q;
    logic [2:0]    digCnt_q;
    logic          frameSync_q;
    logic          wrap;
    logic          rise;

    assign wrap       = (divCnt_q == CW'(DIV - 1));
    assign rise       = wrap && !clk1k_q;
    assign frameStb_o = rise && (digCnt_q == 3'd7);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            divCnt_q    <= '0;
            clk1k_q     <= 1'b0;
            digCnt_q    <= 3'd0;
            frameSync_q <= 1'b0;
        end else begin
            divCnt_q <= wrap ? '0 : divCnt_q + CW'(1);
            if (wrap) begin
                clk1k_q <= ~clk1k_q;
            end
            if (rise) begin
                digCnt_q <= digCnt_q + 3'd1;
            end
            frameSync_q <= frameStb_o;
        end
    end

    assign clk1k_o     = clk1k_q;
    assign frameSync_o = frameSync_q;

endmodule

// File: rtl/disp_sched.sv
// disp_sched
// Display page scheduler. It owns the 32-bit value shown on the 8-digit scan
// path and rotates round-robin among four source pages. A page advances on a
// hold timer, on a manual pulse, or when the shown page is disabled. The
// display value only changes on frame boundaries, so a frame never mixes pages.
//   clk, rst     system clock, synchronous active-high reset
//   page_d       four 32-bit pages, page i in bits [32*i +: 32]
//   page_en      per-page rotation enable
//   auto_en      enable hold-timer rotation (HOLD_FRAMES frames per page)
//   next_pls     one-cycle manual advance request
//   clk_1k       scan clock to the scan driver
//   disp_d       value to the scan driver
//   cur_page     index of the page currently shown
//   frame_sync   one-cycle pulse at each frame boundary
//   active       at least one page is being shown
module disp_sched
    import disp_sched_pkg::*;
#(
    parameter int CLK_HZ      = 50_000_000,
    parameter int SCAN_HZ     = 1000,
    parameter int HOLD_FRAMES = 250
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_PAGE*PAGE_W-1:0] page_d,
    input  logic [N_PAGE-1:0]        page_en,
    input  logic                     auto_en,
    input  logic                     next_pls,
    output logic                     clk_1k,
    output logic [PAGE_W-1:0]        disp_d,
    output logic [IDX_W-1:0]         cur_page,
    output logic                     frame_sync,
    output logic                     active
);

    localparam int DIV    = CLK_HZ / (2 * SCAN_HZ);
    localparam int HOLD_W = $clog2(HOLD_FRAMES + 1);

    logic              frameStb;
    state_e            state_q;
    logic [IDX_W-1:0]  curPage_q;
    logic [PAGE_W-1:0] dispVal_q;
    logic              active_q;
    logic              pend_q;
    logic [HOLD_W-1:0] holdCnt_q;

    logic              anyEn;
    logic              curDis;
    logic              holdHit;
    logic              advReq;
    logic [IDX_W-1:0]  curPage_d;

    disp_sched_scan_clk_gen #(
        .DIV(DIV)
    ) u_scan_clk_gen (
        .clk_i      (clk),
        .rst_i      (rst),
        .clk1k_o    (clk_1k),
        .frameStb_o (frameStb),
        .frameSync_o(frame_sync)
    );

    assign anyEn   = |page_en;
    assign curDis  = !page_en[curPage_q];
    assign holdHit = auto_en && (holdCnt_q == HOLD_W'(HOLD_FRAMES - 1));

    // Outside SHOW only a disabled current page moves the selection. This lets
    // the scheduler land on an enabled page when display starts or resumes.
    // In SHOW the manual, hold and disabled requests merge into one step. A
    // pulse in the boundary cycle itself counts toward that boundary.
    always_comb begin
        advReq = curDis;
        if (state_q == ST_SHOW) begin
            advReq = curDis || pend_q || next_pls || holdHit;
        end
        curPage_d = advReq ? nextEnabled(curPage_q, page_en) : curPage_q;
    end

    // Scheduler FSM and its registered outputs. Everything visible to the scan
    // driver only moves when frameStb is high. This keeps the update aligned
    // with the registered frame_sync pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_INIT;
            curPage_q <= '0;
            dispVal_q <= '0;
            active_q  <= 1'b0;
            pend_q    <= 1'b0;
            holdCnt_q <= '0;
        end else if (frameStb) begin
            pend_q <= 1'b0;
            if (anyEn) begin
                state_q   <= ST_SHOW;
                curPage_q <= curPage_d;
                dispVal_q <= page_d[PAGE_W*int'(curPage_d) +: PAGE_W];
                active_q  <= 1'b1;
                if ((state_q != ST_SHOW) || advReq || !auto_en) begin
                    holdCnt_q <= '0;
                end else begin
                    holdCnt_q <= holdCnt_q + HOLD_W'(1);
                end
            end else begin
                state_q   <= ST_IDLE;
                active_q  <= 1'b0;
                holdCnt_q <= '0;
            end
        end else begin
            if (next_pls) begin
                pend_q <= 1'b1;
            end
            if (!auto_en) begin
                holdCnt_q <= '0;
            end
        end
    end

    assign disp_d   = dispVal_q;
    assign cur_page = curPage_q;
    assign active   = active_q;

endmodule

// File: tb/tb_disp_sched.sv
// tb_disp_sched
// Self-checking bench for disp_sched with DIV=8 (128-cycle frames) and
// HOLD_FRAMES=2. A behavioural model tracks the expected outputs cycle by
// cycle. Directed scenarios add hand-computed literal expectations.
module tb_disp_sched;

    localparam int CLK_HZ  = 16;
    localparam int SCAN_HZ = 1;
    localparam int HOLD    = 2;
    localparam int DIV     = CLK_HZ / (2 * SCAN_HZ);
    localparam int FRAME   = 16 * DIV;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [127:0] page_d = '0;
    logic [3:0]   page_en = '0;
    logic         auto_en = 1'b0;
    logic         next_pls = 1'b0;
    logic         clk_1k;
    logic [31:0]  disp_d;
    logic [1:0]   cur_page;
    logic         frame_sync;
    logic         active;

    int vectors     = 0;
    int miscompares = 0;
    bit checkEn     = 1'b0;

    int          mCyc    = 0;
    logic        mClk    = 1'b0;
    logic        mSync   = 1'b0;
    logic        mActive = 1'b0;
    logic        mPend   = 1'b0;
    logic        mShown  = 1'b0;
    logic [1:0]  mCur    = 2'd0;
    logic [31:0] mDisp   = 32'h0;
    int          mHold   = 0;

    localparam logic [127:0] PAGES_A = {32'h0000_00A3, 32'h0000_00A2, 32'h0000_00A1, 32'h0000_00A0};
    localparam logic [127:0] PAGES_B = {32'hB0B0_0003, 32'hB0B0_0002, 32'hB0B0_0001, 32'hB0B0_0000};
    localparam logic [127:0] PAGES_C = {32'hC0DE_0003, 32'hC0DE_0002, 32'hC0DE_0001, 32'hC0DE_0000};

    disp_sched #(
        .CLK_HZ     (CLK_HZ),
        .SCAN_HZ    (SCAN_HZ),
        .HOLD_FRAMES(HOLD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .page_d    (page_d),
        .page_en   (page_en),
        .auto_en   (auto_en),
        .next_pls  (next_pls),
        .clk_1k    (clk_1k),
        .disp_d    (disp_d),
        .cur_page  (cur_page),
        .frame_sync(frame_sync),
        .active    (active)
    );

    always #5 clk = ~clk;

    // One comparison: bumps the vector count, reports and counts any mismatch.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] en, input logic au, input logic [127:0] pg);
        page_en = en;
        auto_en = au;
        page_d  = pg;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulseNext();
        next_pls = 1'b1;
        @(negedge clk);
        next_pls = 1'b0;
    endtask

    // Waits for the next frame_sync. The wait gives up after two frames and
    // counts that as a miscompare.
    task automatic waitBoundary(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_sync && n < 2 * FRAME);
        if (!frame_sync) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL frame_sync_timeout: no boundary within %0d cycles", n);
        end
    endtask

    task automatic doReset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkEn = 1'b1;
        checkOutput("reset_clk_1k", 32'(clk_1k), 32'h0);
        checkOutput("reset_disp_d", disp_d, 32'h0);
        checkOutput("reset_cur_page", 32'(cur_page), 32'h0);
        checkOutput("reset_frame_sync", 32'(frame_sync), 32'h0);
        checkOutput("reset_active", 32'(active), 32'h0);
        rst = 1'b0;
    endtask

    function automatic logic [1:0] firstAfter(input logic [1:0] cur, input logic [3:0] en);
        for (int j = 1; j <= 4; j++) begin
            if (en[(int'(cur) + j) % 4]) return 2'((int'(cur) + j) % 4);
        end
        return cur;
    endfunction

    // Reference model. The scan clock and boundaries come from the cycle count
    // since reset. Page rules are applied once per boundary.
    always @(posedge clk) begin
        logic want;
        if (rst) begin
            mCyc = 0; mClk = 1'b0; mSync = 1'b0; mActive = 1'b0; mPend = 1'b0;
            mShown = 1'b0; mCur = 2'd0; mDisp = 32'h0; mHold = 0;
        end else begin
            mCyc++;
            mClk  = ((mCyc / DIV) % 2) == 1;
            mSync = (mCyc % FRAME) == (FRAME - DIV);
            if (mSync) begin
                if (page_en == 4'b0000) begin
                    mActive = 1'b0;
                    mShown  = 1'b0;
                    mHold   = 0;
                end else begin
                    want = !page_en[mCur] ||
                           (mShown && (mPend || next_pls || (auto_en && mHold == HOLD - 1)));
                    if (want) mCur = firstAfter(mCur, page_en);
                    if (!mShown || want || !auto_en) mHold = 0;
                    else mHold++;
                    mDisp   = page_d[32*int'(mCur) +: 32];
                    mActive = 1'b1;
                    mShown  = 1'b1;
                end
                mPend = 1'b0;
            end else begin
                if (next_pls) mPend = 1'b1;
                if (!auto_en) mHold = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("model_clk_1k", 32'(clk_1k), 32'(mClk));
            checkOutput("model_frame_sync", 32'(frame_sync), 32'(mSync));
            checkOutput("model_disp_d", disp_d, mDisp);
            checkOutput("model_cur_page", 32'(cur_page), 32'(mCur));
            checkOutput("model_active", 32'(active), 32'(mActive));
        end
    end

    initial begin
        #2_000_000;
        vectors++;
        miscompares++;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        int gap;
        int seqA[9] = '{0, 0, 1, 1, 2, 2, 3, 3, 0};

        // Single page: scan clock period, first boundary, frame spacing.
        applyStimulus(4'b0001, 1'b0, {96'h0, 32'h1234_5678});
        doReset();
        for (int n = 1; n <= 120; n++) begin
            @(negedge clk);
            if (n == 7)  checkOutput("t1_clk_lo_7", 32'(clk_1k), 32'h0);
            if (n == 8)  checkOutput("t1_clk_hi_8", 32'(clk_1k), 32'h1);
            if (n == 16) checkOutput("t1_clk_lo_16", 32'(clk_1k), 32'h0);
            if (n == 24) checkOutput("t1_clk_hi_24", 32'(clk_1k), 32'h1);
            if (n == 119) begin
                checkOutput("t1_pre_active", 32'(active), 32'h0);
                checkOutput("t1_pre_sync", 32'(frame_sync), 32'h0);
            end
            if (n == 120) begin
                checkOutput("t1_first_sync", 32'(frame_sync), 32'h1);
                checkOutput("t1_first_disp", disp_d, 32'h1234_5678);
                checkOutput("t1_first_active", 32'(active), 32'h1);
            end
        end
        waitBoundary(gap);
        checkOutput("t1_frame_spacing", 32'(gap), 32'(FRAME));

        // Auto rotation over all four pages, two frames each.
        applyStimulus(4'b1111, 1'b1, PAGES_A);
        doReset();
        for (int b = 0; b < 9; b++) begin
            waitBoundary(gap);
            checkOutput("t2_cur_page", 32'(cur_page), 32'(seqA[b]));
            checkOutput("t2_disp_d", disp_d, 32'h0000_00A0 + 32'(seqA[b]));
        end

        // Three manual pulses in one frame give a single step 1 -> 3.
        applyStimulus(4'b1010, 1'b0, PAGES_C);
        doReset();
        waitBoundary(gap);
        checkOutput("t3_start_page", 32'(cur_page), 32'h1);
        checkOutput("t3_start_disp", disp_d, 32'hC0DE_0001);
        waitCycles(30);
        for (int p = 0; p < 3; p++) begin
            pulseNext();
            waitCycles(5);
        end
        checkOutput("t3_hold_mid_frame", 32'(cur_page), 32'h1);
        waitBoundary(gap);
        checkOutput("t3_step_page", 32'(cur_page), 32'h3);
        checkOutput("t3_step_disp", disp_d, 32'hC0DE_0003);
        waitBoundary(gap);
        checkOutput("t3_stay_page", 32'(cur_page), 32'h3);

        // Shown page disabled mid-frame, then all pages disabled.
        applyStimulus(4'b0100, 1'b0, PAGES_B);
        doReset();
        waitBoundary(gap);
        checkOutput("t4_start_page", 32'(cur_page), 32'h2);
        waitCycles(20);
        page_en = 4'b0101;
        waitCycles(20);
        page_en = 4'b0001;
        waitBoundary(gap);
        checkOutput("t4_disabled_page", 32'(cur_page), 32'h0);
        checkOutput("t4_disabled_disp", disp_d, 32'hB0B0_0000);
        waitCycles(20);
        page_en = 4'b0000;
        waitBoundary(gap);
        checkOutput("t4_idle_active", 32'(active), 32'h0);
        checkOutput("t4_idle_disp", disp_d, 32'hB0B0_0000);
        waitCycles(20);
        page_en = 4'b0001;
        waitBoundary(gap);
        checkOutput("t4_resume_active", 32'(active), 32'h1);

        // Mid-frame page_d change appears only at the boundary; reset mid-frame.
        waitCycles(20);
        page_d[31:0] = 32'h5A5A_1234;
        waitCycles(50);
        checkOutput("t5_tear_free", disp_d, 32'hB0B0_0000);
        waitBoundary(gap);
        checkOutput("t5_new_disp", disp_d, 32'h5A5A_1234);
        waitCycles(3);
        checkOutput("t5_pre_rst_clk", 32'(clk_1k), 32'h1);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("t5_rst_clk_1k", 32'(clk_1k), 32'h0);
        checkOutput("t5_rst_disp", disp_d, 32'h0);
        checkOutput("t5_rst_cur_page", 32'(cur_page), 32'h0);
        checkOutput("t5_rst_frame_sync", 32'(frame_sync), 32'h0);
        checkOutput("t5_rst_active", 32'(active), 32'h0);
        rst = 1'b0;

        // Manual pulse in the boundary cycle where the hold timer also expires.
        applyStimulus(4'b1111, 1'b1, PAGES_A);
        doReset();
        waitBoundary(gap);
        checkOutput("t6_b1_page", 32'(cur_page), 32'h0);
        waitBoundary(gap);
        checkOutput("t6_b2_page", 32'(cur_page), 32'h0);
        waitCycles(FRAME - 1);
        next_pls = 1'b1;
        @(negedge clk);
        next_pls = 1'b0;
        checkOutput("t6_b3_sync", 32'(frame_sync), 32'h1);
        checkOutput("t6_b3_single_step", 32'(cur_page), 32'h1);
        checkOutput("t6_b3_disp", disp_d, 32'h0000_00A1);
        waitBoundary(gap);
        checkOutput("t6_b4_hold_restart", 32'(cur_page), 32'h1);
        waitBoundary(gap);
        checkOutput("t6_b5_auto_step", 32'(cur_page), 32'h2);

        waitCycles(4);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/disp_sched.md
# disp_sched

Display page scheduler for the 8-digit seven-segment scan path. It generates the ~1 kHz scan clock and owns the 32-bit hex value fed to the scan driver. The value is shared among four source pages, rotated round-robin on a hold timer or a manual advance. The display value changes only on digit-frame boundaries, so a frame never mixes two pages (tear-free).

## Interface
Parameters:
- CLK_HZ, 50_000_000: system clock frequency.
- SCAN_HZ, 1000: scan clock frequency; DIV = CLK_HZ/(2*SCAN_HZ), integer, ≥2.
- HOLD_FRAMES, 250: frames a page stays shown in auto mode (250 frames = 2 s at 125 frames/s); ≥1.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high; single clock domain.
- page_d  in  128  four 32-bit pages; page i = page_d[32*i+31:32*i].
- page_en  in  4  page i takes part in rotation.
- auto_en  in  1  enable hold-timer rotation.
- next_pls  in  1  one-cycle manual-advance request.
- clk_1k  out  1  50 % scan clock to the scan driver; reset 0.
- disp_d  out  32  value to the scan driver; reset 32'h0.
- cur_page  out  2  page currently shown; reset 0.
- frame_sync  out  1  one-cycle pulse at each frame boundary; reset 0.
- active  out  1  at least one page is shown; reset 0.

## Operation
- Divider: div_cnt counts 0..DIV-1 and wraps. clk_1k toggles on the wrap.
- A rising edge of clk_1k (0→1 toggle) increments dig_cnt[2:0]. dig_cnt resets to 0.
- Frame boundary: the cycle in which clk_1k rises and dig_cnt goes 7→0. frame_sync is high in that cycle only.
- Frame boundaries occur every 8 scan periods, i.e. every 16*DIV clk cycles.
- Advance request:
  - next_pls sets the pend flag. Any number of pulses before a boundary gives one advance.
  - pend clears at the boundary that consumes it.
  - A pulse in the boundary cycle itself is consumed by that boundary.
- hold_cnt:
  - Counts boundaries while auto_en=1.
  - Reaching HOLD_FRAMES-1 requests an advance.
  - Cleared on every advance and whenever auto_en=0.
- Current page disabled (page_en[cur_page]=0) also requests an advance.
- At each boundary, if an advance is requested:
  - Select the first enabled index after cur_page, searching (cur_page+1..cur_page+3, then cur_page) mod 4.
  - Selection is combinational, a single-cycle priority scan.
  - Simultaneous requests (manual, hold, disabled page) cause exactly one step.
- At each boundary with at least one page enabled: disp_d ← page_d of the (new) cur_page; active ← 1.
- At a boundary with no page enabled: active ← 0; disp_d and cur_page hold.
- When a page is later enabled, it is selected at the next boundary.
- Between boundaries, disp_d, cur_page and active never change.
- page_d changes mid-frame appear at the next boundary.
- State machine (2 bits):
  - INIT → SHOW at the first boundary with any page enabled; INIT → IDLE at the first boundary otherwise.
  - SHOW → IDLE at a boundary with page_en=0.
  - IDLE → SHOW at a boundary with page_en≠0.
  - In SHOW, advances occur as described above.
- Reset mid-operation: all registers, pend, hold_cnt and outputs return to reset values in the next cycle. No partial frame is completed.

## Timing
- clk_1k period = 2*DIV clk cycles.
- frame_sync is registered and aligns with the cycle clk_1k goes high for dig_cnt=0.
- disp_d, cur_page and active update in the same cycle as frame_sync (registered off the boundary condition). Latency from page_d change to disp_d is 1..16*DIV cycles.
- next_pls to page change: the next boundary. If the pulse lands in the boundary cycle, it is that boundary.
- Auto dwell: exactly HOLD_FRAMES frames per page with ≥2 pages enabled.
- With 1 page enabled, advances re-select the same page; disp_d still refreshes.

## Structure
- Shared header disp_defs.vh: N_PAGE=4, PAGE_W=32, page-index width 2, state encodings INIT/SHOW/IDLE.
- One sub-module, scan_clk_gen (div_cnt, clk_1k, dig_cnt, frame-boundary strobe, parameter DIV). Page selection, pend, hold_cnt and the FSM stay in disp_sched.

## Test plan
Bench parameters: CLK_HZ=16, SCAN_HZ=1 (DIV=8, frame=128 cycles), HOLD_FRAMES=2.
- Reset, then page_en=4'b0001, page_d[31:0]=32'h12345678 → clk_1k period 16; frame_sync at 128-cycle spacing; disp_d=32'h12345678, active=1 at the first boundary.
- page_en=4'b1111, auto_en=1, pages 32'hA0..A3 → cur_page sequence 0,1,2,3,0, two frames each; disp_d changes only with frame_sync.
- page_en=4'b1010, three next_pls mid-frame, auto_en=0 → a single step 1→3 at the next boundary, then cur_page stays 3.
- Shown page 2 disabled mid-frame (page_en 4'b0101→4'b0001) → at the boundary cur_page=0, disp_d=page 0; page_en=0 → active=0, disp_d holds.
- Change page_d mid-frame → disp_d unchanged until the boundary. Assert rst mid-frame → next cycle: clk_1k=0, disp_d=0, cur_page=0, frame_sync=0, active=0.
- next_pls coincident with hold expiry → exactly one advance; hold_cnt restarts from 0.
